// File: rtl/gpu_rect_fill.sv
// Rectangle-fill engine: takes one (origin, size, colour) command and streams
// row-major, screen-clipped pixel writes into the framebuffer write port.
module gpu_rect_fill #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int ADDR_W    = 15,
  parameter int COLOR_W   = 3
) (
  input  logic               CLK_SYS,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [7:0]         CMD_X,
  input  logic [6:0]         CMD_Y,
  input  logic [7:0]         CMD_W,
  input  logic [6:0]         CMD_H,
  input  logic [COLOR_W-1:0] CMD_COLOR,
  output logic               FB_WE,
  output logic [ADDR_W-1:0]  FB_ADDR,
  output logic [COLOR_W-1:0] FB_DATA,
  input  logic               FB_READY,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [8:0]        LP_XMAX   = 9'(FB_WIDTH);
  localparam logic [7:0]        LP_YMAX   = 8'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] LP_STRIDE = ADDR_W'(FB_WIDTH);

  state_t r_state;
  state_t w_state_nx;

  logic [7:0]         r_x;
  logic [6:0]         r_y;
  logic [7:0]         r_w;
  logic [6:0]         r_h;
  logic [COLOR_W-1:0] r_color;
  logic [8:0]         r_x_end;
  logic [7:0]         r_y_end;
  logic [8:0]         r_col;
  logic [7:0]         r_row;
  logic [ADDR_W-1:0]  r_row_base;
  logic [ADDR_W-1:0]  r_addr;

  logic [8:0]        w_xsum;
  logic [7:0]        w_ysum;
  logic              w_empty;
  logic [ADDR_W-1:0] w_base;
  logic [8:0]        w_col_nx;
  logic [7:0]        w_row_nx;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_accept;
  logic              w_fire;

  assign w_xsum     = {1'b0, r_x} + {1'b0, r_w};
  assign w_ysum     = {1'b0, r_y} + {1'b0, r_h};
  assign w_empty    = (r_w == '0) || (r_h == '0) ||
                      ({1'b0, r_x} >= LP_XMAX) || ({1'b0, r_y} >= LP_YMAX);
  assign w_base     = ADDR_W'(r_y) * LP_STRIDE + ADDR_W'(r_x);
  assign w_col_nx   = r_col + 9'd1;
  assign w_row_nx   = r_row + 8'd1;
  assign w_col_last = (w_col_nx == r_x_end);
  assign w_row_last = (w_row_nx == r_y_end);
  assign w_accept   = (r_state == S_IDLE) && CMD_VALID;
  assign w_fire     = (r_state == S_RUN) && FB_READY;

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    CMD_READY  = 1'b0;
    FB_WE      = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (r_state)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) w_state_nx = S_SETUP;
      end
      S_SETUP: begin
        BUSY       = 1'b1;
        w_state_nx = w_empty ? S_FIN : S_RUN;
      end
      S_RUN: begin
        BUSY  = 1'b1;
        FB_WE = 1'b1;
        if (FB_READY && w_col_last && w_row_last) w_state_nx = S_FIN;
      end
      S_FIN: begin
        DONE       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // r_addr tracks row_base + (col - X) incrementally so no subtract sits on the output path.
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else begin
      if (w_accept) begin
        r_x     <= CMD_X;
        r_y     <= CMD_Y;
        r_w     <= CMD_W;
        r_h     <= CMD_H;
        r_color <= CMD_COLOR;
      end
      if (r_state == S_SETUP) begin
        r_x_end    <= (w_xsum > LP_XMAX) ? LP_XMAX : w_xsum;
        r_y_end    <= (w_ysum > LP_YMAX) ? LP_YMAX : w_ysum;
        r_col      <= {1'b0, r_x};
        r_row      <= {1'b0, r_y};
        r_row_base <= w_base;
        r_addr     <= w_base;
      end
      if (w_fire) begin
        if (w_col_last) begin
          r_col      <= {1'b0, r_x};
          r_row      <= w_row_nx;
          r_row_base <= r_row_base + LP_STRIDE;
          r_addr     <= r_row_base + LP_STRIDE;
        end else begin
          r_col  <= w_col_nx;
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  assign FB_ADDR = r_addr;
  assign FB_DATA = r_color;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Self-checking bench for gpu_rect_fill: directed screen cases plus randomized
// commands compared against a nested-loop clipped-pixel reference list.
module tb_gpu_rect_fill;

  localparam int FBW = 160;
  localparam int FBH = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [2:0]  cmd_color;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int unsigned obs_q[$];
  int done_cyc;

  always #5 clk = ~clk;

  gpu_rect_fill #(
    .FB_WIDTH (160),
    .FB_HEIGHT(120),
    .ADDR_W   (15),
    .COLOR_W  (3)
  ) dut (
    .CLK_SYS  (clk),
    .RST      (rst),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD_X    (cmd_x),
    .CMD_Y    (cmd_y),
    .CMD_W    (cmd_w),
    .CMD_H    (cmd_h),
    .CMD_COLOR(cmd_color),
    .FB_WE    (fb_we),
    .FB_ADDR  (fb_addr),
    .FB_DATA  (fb_data),
    .FB_READY (fb_ready),
    .BUSY     (busy),
    .DONE     (done)
  );

  // mode 0: ready always high; 1: random ready; 2: ready pattern 1,0,0,1,0,0...
  task automatic do_fill(input int x, input int y, input int w, input int h,
                         input int c, input int mode);
    int unsigned exp_q[$];
    int cyc;
    int idx;
    int wecount;
    int limit;
    bit stalled;
    bit done_seen;
    logic [14:0] p_addr;
    logic [2:0]  p_data;
    for (int r = y; r < y + h; r++)
      for (int k = x; k < x + w; k++)
        if (r < FBH && k < FBW) exp_q.push_back(r * FBW + k);
    obs_q.delete();
    idx = 0; wecount = 0; stalled = 0; done_seen = 0; done_cyc = -1;
    p_addr = '0; p_data = '0;
    limit = 40 * exp_q.size() + 50;

    @(negedge clk);
    for (int t = 0; t < 8 && cmd_ready !== 1'b1; t++) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
      return;
    end
    cmd_x = x[7:0]; cmd_y = y[6:0]; cmd_w = w[7:0]; cmd_h = h[6:0];
    cmd_color = c[2:0]; cmd_valid = 1'b1;
    fb_ready = 1'($urandom_range(0, 1));

    @(negedge clk);
    cyc = 1;
    cmd_valid = 1'b0;
    cmd_x = 8'($urandom); cmd_y = 7'($urandom); cmd_w = 8'($urandom);
    cmd_h = 7'($urandom); cmd_color = 3'($urandom);
    checks++;
    if (busy !== 1'b1 || fb_we !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL setup_state: busy=%b we=%b rdy=%b done=%b want 1,0,0,0",
               busy, fb_we, cmd_ready, done);
    end
    fb_ready = 1'($urandom_range(0, 1));

    while (!done_seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        checks++;
        if (fb_we !== (exp_q.size() > 0)) begin
          failures++;
          $display("FAIL first_we_latency: we=%b want %b", fb_we, exp_q.size() > 0);
        end
      end
      if (stalled && fb_we === 1'b1) begin
        checks++;
        if (fb_addr !== p_addr || fb_data !== p_data) begin
          failures++;
          $display("FAIL stall_hold: addr=%0d data=%0d want addr=%0d data=%0d",
                   fb_addr, fb_data, p_addr, p_data);
        end
      end
      if (fb_we === 1'b1) begin
        checks++;
        if (idx >= exp_q.size()) begin
          failures++;
          $display("FAIL extra_write: addr=%0d want no write (expected %0d)", fb_addr, exp_q.size());
        end else if (fb_addr !== exp_q[idx] || fb_data !== c[2:0]) begin
          failures++;
          $display("FAIL write_%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                   idx, fb_addr, fb_data, exp_q[idx], c[2:0]);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL run_flags: busy=%b done=%b rdy=%b want 1,0,0", busy, done, cmd_ready);
        end
        case (mode)
          0:       fb_ready = 1'b1;
          2:       fb_ready = (wecount % 3 == 0);
          default: fb_ready = 1'($urandom_range(0, 1));
        endcase
        wecount++;
        if (fb_ready) begin
          obs_q.push_back(int'(fb_addr));
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          p_addr = fb_addr;
          p_data = fb_data;
        end
      end else begin
        stalled = 0;
        fb_ready = 1'($urandom_range(0, 1));
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL we_gap: cyc=%0d we=0 done=%b want write or done", cyc, done);
        end else begin
          done_seen = 1;
          done_cyc = cyc;
          checks++;
          if (idx != exp_q.size() || cyc != 2 + wecount || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_state: writes=%0d cyc=%0d busy=%b rdy=%b want writes=%0d cyc=%0d busy=0 rdy=0",
                     idx, cyc, busy, cmd_ready, exp_q.size(), 2 + wecount);
          end
        end
      end
    end
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL done_timeout: no DONE within %0d cycles, want DONE", limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (cmd_ready !== 1'b1 || fb_we !== 1'b0 || fb_addr !== 15'd0 || fb_data !== 3'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%0d data=%0d busy=%b done=%b want 1,0,0,0,0,0",
               cmd_ready, fb_we, fb_addr, fb_data, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_screen();
    do_fill(0, 0, 160, 120, 5, 0);
    checks++;
    if (obs_q.size() != 19200 || done_cyc != 19202) begin
      failures++;
      $display("FAIL full_screen: writes=%0d done_cyc=%0d want 19200,19202", obs_q.size(), done_cyc);
    end else begin
      checks++;
      if (obs_q[0] != 0 || obs_q[19199] != 19199) begin
        failures++;
        $display("FAIL full_screen_ends: first=%0d last=%0d want 0,19199", obs_q[0], obs_q[19199]);
      end
    end
  endtask

  task automatic test_small();
    int unsigned want[6] = '{810, 811, 812, 970, 971, 972};
    do_fill(10, 5, 3, 2, 2, 0);
    checks++;
    if (obs_q.size() != 6 || done_cyc != 8) begin
      failures++;
      $display("FAIL small_count: writes=%0d done_cyc=%0d want 6,8", obs_q.size(), done_cyc);
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[i] != want[i]) begin
          failures++;
          $display("FAIL small_addr_%0d: got %0d want %0d", i, obs_q[i], want[i]);
        end
      end
  endtask

  task automatic test_clip();
    int unsigned want[4] = '{19038, 19039, 19198, 19199};
    do_fill(158, 118, 10, 10, 7, 0);
    checks++;
    if (obs_q.size() != 4) begin
      failures++;
      $display("FAIL clip_count: writes=%0d want 4", obs_q.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i] != want[i]) begin
          failures++;
          $display("FAIL clip_addr_%0d: got %0d want %0d", i, obs_q[i], want[i]);
        end
      end
  endtask

  task automatic test_empty();
    int ex[3] = '{5, 200, 5};
    int ey[3] = '{5, 5, 120};
    int ew[3] = '{0, 4, 4};
    for (int i = 0; i < 3; i++) begin
      do_fill(ex[i], ey[i], ew[i], 3, 1, 1);
      checks++;
      if (obs_q.size() != 0 || done_cyc != 2) begin
        failures++;
        $display("FAIL empty_%0d: writes=%0d done_cyc=%0d want 0,2", i, obs_q.size(), done_cyc);
      end
    end
  endtask

  task automatic test_stall();
    int unsigned want[6] = '{810, 811, 812, 970, 971, 972};
    do_fill(10, 5, 3, 2, 2, 2);
    checks++;
    if (obs_q.size() != 6 || done_cyc != 2 + 16) begin
      failures++;
      $display("FAIL stall_count: writes=%0d done_cyc=%0d want 6,18", obs_q.size(), done_cyc);
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[i] != want[i]) begin
          failures++;
          $display("FAIL stall_addr_%0d: got %0d want %0d", i, obs_q[i], want[i]);
        end
      end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++)
      do_fill($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 20),
              $urandom_range(0, 8), $urandom_range(0, 7), (i % 4 == 0) ? 0 : 1);
  endtask

  task automatic test_reset_mid_fill();
    int nwr;
    @(negedge clk);
    cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd50; cmd_h = 7'd50; cmd_color = 3'd6;
    cmd_valid = 1'b1; fb_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    nwr = 0;
    for (int t = 0; t < 10 && nwr < 3; t++) begin
      @(negedge clk);
      if (fb_we === 1'b1) nwr++;
    end
    checks++;
    if (nwr != 3) begin
      failures++;
      $display("FAIL midfill_start: writes=%0d want 3", nwr);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fb_we !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midfill_async: we=%b done=%b rdy=%b busy=%b want 0,0,1,0",
               fb_we, done, cmd_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || fb_we !== 1'b0) begin
        failures++;
        $display("FAIL midfill_quiet: done=%b we=%b want 0,0", done, fb_we);
      end
    end
    do_fill(0, 0, 1, 1, 3, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] != 0) begin
      failures++;
      $display("FAIL midfill_new: writes=%0d first=%0d want 1,0", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 32'hFFFF);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    fb_ready = 1'b0;
    test_reset();
    test_small();
    test_clip();
    test_empty();
    test_stall();
    test_full_screen();
    test_back_to_back();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
